// File: rtl/i2c_frame_counter_pkg.sv
// Shared I2C datapath types and default field widths.
// Imported by the frame counter and the master/slave FSMs.
package i2c_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        ACK  = 2'd2
    } frame_state_t;

    localparam int BIT_W_DEF  = 4;
    localparam int WORD_W_DEF = 8;

endpackage

// File: rtl/i2c_frame_counter_if.sv
// Control/status bundle between an I2C FSM (master) and the frame counter (slave).
// Widths follow the counter's BIT_W/WORD_W parameters.
interface i2c_frame_counter_if import i2c_pkg::*; #(
    parameter int BIT_W  = BIT_W_DEF,
    parameter int WORD_W = WORD_W_DEF
);
    logic              start;
    logic [BIT_W-1:0]  len;
    logic [WORD_W-1:0] words;
    logic              tick;
    logic              abort;
    logic              busy;
    logic [BIT_W-1:0]  bit_idx;
    logic [WORD_W-1:0] word_idx;
    logic              last_bit;
    logic              ack_slot;
    logic              word_done;
    logic              frame_done;
    logic              cfg_err;

    modport master (
        output start, len, words, tick, abort,
        input  busy, bit_idx, word_idx, last_bit, ack_slot, word_done, frame_done, cfg_err
    );

    modport slave (
        input  start, len, words, tick, abort,
        output busy, bit_idx, word_idx, last_bit, ack_slot, word_done, frame_done, cfg_err
    );
endinterface

// File: rtl/i2c_frame_counter.sv
// Bit/word sequencer: counts len bits (+ optional ACK slot) per word, words per frame, on tick.
// All outputs come from registered state; results of an event at cycle n appear at n+1.
module i2c_frame_counter import i2c_pkg::*; #(
    parameter int BIT_W  = BIT_W_DEF,
    parameter int WORD_W = WORD_W_DEF,
    parameter bit ACK_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    i2c_frame_counter_if.slave  bus
);

    localparam logic [BIT_W-1:0]  BIT_ONE  = BIT_W'(1);
    localparam logic [WORD_W-1:0] WORD_ONE = WORD_W'(1);

    frame_state_t      r_state,      w_state;
    logic [BIT_W-1:0]  r_bit_idx,    w_bit_idx;
    logic [WORD_W-1:0] r_word_idx,   w_word_idx;
    logic [BIT_W-1:0]  r_len_q,      w_len_q;
    logic [WORD_W-1:0] r_words_q,    w_words_q;
    logic              r_word_done,  w_word_done;
    logic              r_frame_done, w_frame_done;
    logic              r_cfg_err,    w_cfg_err;
    logic              w_word_end;
    logic              w_last_bit;
    logic              w_last_word;

    assign w_last_bit  = (r_state == DATA) && (r_bit_idx == r_len_q - BIT_ONE);
    assign w_last_word = (r_word_idx == r_words_q - WORD_ONE);

    // Priority abort > start > tick; terminal compares happen before any increment.
    always_comb begin
        w_state      = r_state;
        w_bit_idx    = r_bit_idx;
        w_word_idx   = r_word_idx;
        w_len_q      = r_len_q;
        w_words_q    = r_words_q;
        w_word_done  = 1'b0;
        w_frame_done = 1'b0;
        w_cfg_err    = 1'b0;
        w_word_end   = 1'b0;

        if (bus.abort) begin
            w_state    = IDLE;
            w_bit_idx  = '0;
            w_word_idx = '0;
        end else if (bus.start) begin
            w_bit_idx  = '0;
            w_word_idx = '0;
            if ((bus.len != '0) && (bus.words != '0)) begin
                w_len_q   = bus.len;
                w_words_q = bus.words;
                w_state   = DATA;
            end else begin
                w_cfg_err = 1'b1;
                w_state   = IDLE;
            end
        end else if (bus.tick) begin
            case (r_state)
                DATA: begin
                    if (!w_last_bit)
                        w_bit_idx = r_bit_idx + BIT_ONE;
                    else if (ACK_EN)
                        w_state = ACK;
                    else
                        w_word_end = 1'b1;
                end
                ACK:     w_word_end = 1'b1;
                default: w_state = IDLE;
            endcase
        end

        if (w_word_end) begin
            w_word_done = 1'b1;
            w_bit_idx   = '0;
            if (w_last_word) begin
                w_frame_done = 1'b1;
                w_word_idx   = '0;
                w_state      = IDLE;
            end else begin
                w_word_idx = r_word_idx + WORD_ONE;
                w_state    = DATA;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_bit_idx    <= '0;
            r_word_idx   <= '0;
            r_len_q      <= '0;
            r_words_q    <= '0;
            r_word_done  <= 1'b0;
            r_frame_done <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_bit_idx    <= w_bit_idx;
            r_word_idx   <= w_word_idx;
            r_len_q      <= w_len_q;
            r_words_q    <= w_words_q;
            r_word_done  <= w_word_done;
            r_frame_done <= w_frame_done;
            r_cfg_err    <= w_cfg_err;
        end
    end

    assign bus.busy       = (r_state != IDLE);
    assign bus.bit_idx    = r_bit_idx;
    assign bus.word_idx   = r_word_idx;
    assign bus.last_bit   = w_last_bit;
    assign bus.ack_slot   = (r_state == ACK);
    assign bus.word_done  = r_word_done;
    assign bus.frame_done = r_frame_done;
    assign bus.cfg_err    = r_cfg_err;

endmodule

// File: doc/i2c_frame_counter.md
# i2c_frame_counter

Parametrised bit/word sequencer for the I2C datapath. It succeeds the fixed 3-bit, 8-count bit counter. It counts a programmable number of bits per word and optionally inserts an ACK slot after each word. It spans a programmable number of words per frame, advancing only on a qualifying `tick` (e.g. SCL edge strobe from the bus timing block). The master/slave FSMs use it to know the current bit index, when the ACK slot is live, and when a word or the whole frame has finished.

## Interface
Parameters:
- `BIT_W`, 4: width of bit-length and bit-index fields; max word length 2^BIT_W−1.
- `WORD_W`, 8: width of word-count fields; max frame 2^WORD_W−1 words.
- `ACK_EN`, 1: 1 inserts one ACK slot per word; 0 means no ACK slot.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: load `len`/`words`, begin a frame (restarts if busy).
- `len` in BIT_W: data bits per word, valid 1..2^BIT_W−1.
- `words` in WORD_W: words per frame, valid 1..2^WORD_W−1.
- `tick` in 1: advance strobe, one bit period per asserted cycle.
- `abort` in 1: terminate the frame immediately.
- `busy` out 1: state ≠ IDLE.
- `bit_idx` out BIT_W: current data bit index, 0-based.
- `word_idx` out WORD_W: current word index, 0-based.
- `last_bit` out 1: DATA and `bit_idx == len_q−1`.
- `ack_slot` out 1: state == ACK.
- `word_done` out 1: one-cycle pulse at the end of each word.
- `frame_done` out 1: one-cycle pulse at the end of the final word.
- `cfg_err` out 1: one-cycle pulse on `start` with `len==0` or `words==0`.

## Operation
- States: IDLE, DATA, ACK. ACK is unreachable when `ACK_EN=0`.
- IDLE:
  - `start` with valid config latches `len_q`, `words_q`, clears the indices and enters DATA.
  - `start` with an invalid config pulses `cfg_err` and stays IDLE.
- DATA, `tick` and not `last_bit`: `bit_idx++`.
- DATA, `tick` and `last_bit`:
  - `ACK_EN=1`: enter ACK.
  - `ACK_EN=0`: execute the word-end rule.
- ACK, `tick`: execute the word-end rule.
- Word-end rule:
  - Pulse `word_done`.
  - If `word_idx == words_q−1`: pulse `frame_done`, go to IDLE, clear the indices.
  - Else: `word_idx++`, `bit_idx=0`, go to DATA.
- `tick` in IDLE is ignored.
- `tick` absent: all state holds.
- `start` while busy:
  - Restarts with the new config from the next cycle.
  - No `word_done`/`frame_done` for the abandoned frame, even if a word-end tick coincides.
  - Invalid config in this case pulses `cfg_err` and forces IDLE.
- `abort`:
  - Forces IDLE and clears the indices next cycle.
  - Emits no done pulses.
  - Has priority over `start` and `tick` in the same cycle.
- Priority: `rst` > `abort` > `start` > `tick`.
- `len`/`words` are sampled only on `start`. Later changes have no effect.
- Arithmetic: indices are unsigned and never wrap. The terminal compare precedes the increment, so `bit_idx ≤ len_q−1` and `word_idx ≤ words_q−1` always hold.

## Timing
- All outputs are registered or decoded from registered state only. No input-to-output combinational path.
- `rst` response:
  - IDLE.
  - `bit_idx`, `word_idx`, `len_q`, `words_q` = 0.
  - All 1-bit outputs = 0.
- `start` at cycle n: `busy=1`, `bit_idx=0`, `word_idx=0` at n+1.
- A `tick` at cycle n updates state/indices visible at n+1.
- `word_done`, `frame_done` and `cfg_err` are high exactly at n+1 for their causing event at n, for one cycle.
- Frame length with a continuous `tick` is `words·(len+ACK_EN)` cycles. `busy` falls in the same cycle `frame_done` rises.
- A back-to-back `start` in the `frame_done` cycle is accepted normally.

## Structure
- `i2c_pkg`:
  - `frame_state_t` enum {IDLE, DATA, ACK}.
  - Default `BIT_W`/`WORD_W` localparams shared with the I2C FSMs.
- Single module, no sub-module. Bit and word counters are inline registers, with next-state logic in one combinational block.

## Test plan
- `len=8`, `words=2`, `ACK_EN=1`, continuous `tick`:
  - `bit_idx` 0..7 then `ack_slot` high one cycle; `word_done` at cycles 10 and 19.
  - `frame_done` at 19; `busy` low at 19.
- `len=3`, `words=1`, `ACK_EN=0`, `tick` every third cycle: `bit_idx` holds between ticks; `frame_done` one cycle after the third tick.
- `start` with `len=0`, then `words=0`: `cfg_err` pulses each time and `busy` stays 0.
- Mid-frame `start` (`len=5`) at `bit_idx=4` of `len=8`: next cycle `bit_idx=0`, `word_idx=0`; new frame is 5 bits per word; no stale `word_done`.
- `abort`, `start` and `tick` in the same cycle at word 1: next cycle IDLE, indices 0, no pulses.
- `rst` asserted during ACK of word 0: next cycle all outputs 0. A following `start` (`len=2`, `words=1`) completes in 3 ticks.
